// File: rtl/wrapping_decrement_counter_pkg.sv
// Shared helpers for the wrapping counter family.
// Holds the header macros used to size counters and pick the wrap
// implementation, plus the package the counter files import.

`ifndef WRAPPING_COUNTER_MACROS
`define WRAPPING_COUNTER_MACROS
`define CLOG2(x) $clog2(x)
`define IS_POW2(x) ((((x) & ((x) - 1)) == 0) ? 1'b1 : 1'b0)
`endif

package wrapping_decrement_counter_pkg;
    // Number of state bits the counter carries besides count (lap, underflow).
    localparam int unsigned WDC_FLAG_BITS = 2;
endpackage

// File: rtl/wrapping_decrement_counter.sv
// Wrapping down-counter: counts 0 .. RANGE-1, wraps from 0 to RANGE-1.
// Provides a lap bit that toggles on every wrap, a registered underflow
// pulse, a zero flag and a synchronous load that clamps out-of-range values.
// Priority per edge: load > decrement > hold.

`ifndef WRAPPING_COUNTER_MACROS
`define WRAPPING_COUNTER_MACROS
`define CLOG2(x) $clog2(x)
`define IS_POW2(x) ((((x) & ((x) - 1)) == 0) ? 1'b1 : 1'b0)
`endif

module wrapping_decrement_counter
    import wrapping_decrement_counter_pkg::*;
#(
    parameter int unsigned RANGE       = 4,
    parameter int unsigned RANGE_LOG2  = `CLOG2(RANGE),
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  decrement,
    input  logic                  load,
    input  logic [RANGE_LOG2-1:0] load_value,
    output logic [RANGE_LOG2-1:0] count,
    output logic                  lap,
    output logic                  is_zero,
    output logic                  underflow
);

    localparam logic [RANGE_LOG2-1:0] COUNTER_MIN = '0;
    localparam logic [RANGE_LOG2-1:0] COUNTER_MAX = RANGE_LOG2'(RANGE - 1);

    logic [RANGE_LOG2-1:0] count_q, count_d;
    logic                  lap_q, lap_d;
    logic                  underflow_q, underflow_d;

    // Value count takes on a decrement, already wrapped into range.
    logic [RANGE_LOG2-1:0] dec_count;
    // Load value forced into range; values >= RANGE saturate at the top.
    logic [RANGE_LOG2-1:0] load_clamped;
    logic                  at_zero;

    assign at_zero = (count_q == COUNTER_MIN);

    generate
        if (`IS_POW2(RANGE)) begin : gen_pow2_counter
            // Modular subtraction at RANGE_LOG2 bits wraps 0 to RANGE-1 for free.
            assign dec_count = count_q - RANGE_LOG2'(1);
        end else begin : gen_non_pow2_counter
            // Unused top codes must never appear, so 0 explicitly selects RANGE-1.
            assign dec_count = at_zero ? COUNTER_MAX : (count_q - RANGE_LOG2'(1));
        end
    endgenerate

    // Clamp loads; for power-of-2 ranges the compare is never true.
    assign load_clamped = (32'(load_value) >= RANGE) ? COUNTER_MAX : load_value;

    // Next-state selection: load beats decrement, idle holds count and lap.
    always_comb begin
        count_d     = count_q;
        lap_d       = lap_q;
        underflow_d = 1'b0;
        if (load) begin
            count_d = load_clamped;
            lap_d   = 1'b0;
        end else if (decrement) begin
            count_d = dec_count;
            if (at_zero) begin
                lap_d       = ~lap_q;
                underflow_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q     <= RANGE_LOG2'(RESET_VALUE);
            lap_q       <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            lap_q       <= lap_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign lap       = lap_q;
    assign underflow = underflow_q;
    assign is_zero   = at_zero;

endmodule

// File: tb/tb_wrapping_decrement_counter.sv
// Directed bench for wrapping_decrement_counter. Several instances with
// different RANGE values share one stimulus stream; each directed block
// checks the instance it targets, and a randomised section compares five
// instances against a small reference model.

module tb_wrapping_decrement_counter;

    logic       clock;
    logic       resetn;
    logic       decrement;
    logic       load;
    logic [2:0] load_value;

    int n_checks;
    int n_fail;

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT instances ----------------
    logic [2:0] count_r5; logic lap_r5, zero_r5, uf_r5;
    logic [1:0] count_r4; logic lap_r4, zero_r4, uf_r4;
    logic [0:0] count_r2; logic lap_r2, zero_r2, uf_r2;
    logic [2:0] count_r6; logic lap_r6, zero_r6, uf_r6;
    logic [1:0] count_r3; logic lap_r3, zero_r3, uf_r3;
    logic [2:0] count_r7; logic lap_r7, zero_r7, uf_r7;
    logic [2:0] count_r8; logic lap_r8, zero_r8, uf_r8;

    wrapping_decrement_counter #(.RANGE(5), .RESET_VALUE(0)) u_r5 (
        .clock(clock), .resetn(resetn), .decrement(decrement), .load(load),
        .load_value(load_value[2:0]), .count(count_r5), .lap(lap_r5),
        .is_zero(zero_r5), .underflow(uf_r5));
    wrapping_decrement_counter #(.RANGE(4), .RESET_VALUE(0)) u_r4 (
        .clock(clock), .resetn(resetn), .decrement(decrement), .load(load),
        .load_value(load_value[1:0]), .count(count_r4), .lap(lap_r4),
        .is_zero(zero_r4), .underflow(uf_r4));
    wrapping_decrement_counter #(.RANGE(2), .RESET_VALUE(0)) u_r2 (
        .clock(clock), .resetn(resetn), .decrement(decrement), .load(load),
        .load_value(load_value[0:0]), .count(count_r2), .lap(lap_r2),
        .is_zero(zero_r2), .underflow(uf_r2));
    wrapping_decrement_counter #(.RANGE(6), .RESET_VALUE(3)) u_r6 (
        .clock(clock), .resetn(resetn), .decrement(decrement), .load(load),
        .load_value(load_value[2:0]), .count(count_r6), .lap(lap_r6),
        .is_zero(zero_r6), .underflow(uf_r6));
    wrapping_decrement_counter #(.RANGE(3), .RESET_VALUE(0)) u_r3 (
        .clock(clock), .resetn(resetn), .decrement(decrement), .load(load),
        .load_value(load_value[1:0]), .count(count_r3), .lap(lap_r3),
        .is_zero(zero_r3), .underflow(uf_r3));
    wrapping_decrement_counter #(.RANGE(7), .RESET_VALUE(0)) u_r7 (
        .clock(clock), .resetn(resetn), .decrement(decrement), .load(load),
        .load_value(load_value[2:0]), .count(count_r7), .lap(lap_r7),
        .is_zero(zero_r7), .underflow(uf_r7));
    wrapping_decrement_counter #(.RANGE(8), .RESET_VALUE(0)) u_r8 (
        .clock(clock), .resetn(resetn), .decrement(decrement), .load(load),
        .load_value(load_value[2:0]), .count(count_r8), .lap(lap_r8),
        .is_zero(zero_r8), .underflow(uf_r8));

    // Random-section views: index 0..4 -> RANGE 3,4,5,7,8
    logic [2:0] rnd_cnt  [5];
    logic       rnd_lap  [5];
    logic       rnd_zero [5];
    logic       rnd_uf   [5];
    assign rnd_cnt[0] = {1'b0, count_r3};  assign rnd_lap[0] = lap_r3;
    assign rnd_cnt[1] = {1'b0, count_r4};  assign rnd_lap[1] = lap_r4;
    assign rnd_cnt[2] = count_r5;          assign rnd_lap[2] = lap_r5;
    assign rnd_cnt[3] = count_r7;          assign rnd_lap[3] = lap_r7;
    assign rnd_cnt[4] = count_r8;          assign rnd_lap[4] = lap_r8;
    assign rnd_zero[0] = zero_r3;  assign rnd_uf[0] = uf_r3;
    assign rnd_zero[1] = zero_r4;  assign rnd_uf[1] = uf_r4;
    assign rnd_zero[2] = zero_r5;  assign rnd_uf[2] = uf_r5;
    assign rnd_zero[3] = zero_r7;  assign rnd_uf[3] = uf_r7;
    assign rnd_zero[4] = zero_r8;  assign rnd_uf[4] = uf_r8;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model for the random section ----------------
    int m_range [5] = '{3, 4, 5, 7, 8};
    int m_width [5] = '{2, 2, 3, 3, 3};
    int m_cnt   [5];
    int m_lap   [5];
    int m_uf    [5];

    task automatic model_edge(input logic ld, input logic dec, input logic [2:0] lv);
        for (int i = 0; i < 5; i++) begin
            int lvw;
            lvw = int'(lv) & ((1 << m_width[i]) - 1);
            if (ld) begin
                m_cnt[i] = (lvw >= m_range[i]) ? m_range[i] - 1 : lvw;
                m_lap[i] = 0;
                m_uf[i]  = 0;
            end else if (dec) begin
                if (m_cnt[i] == 0) begin
                    m_cnt[i] = m_range[i] - 1;
                    m_lap[i] = 1 - m_lap[i];
                    m_uf[i]  = 1;
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                    m_uf[i]  = 0;
                end
            end else begin
                m_uf[i] = 0;
            end
        end
    endtask

    // Directed expectation tables
    int r5_cnt [6] = '{4, 3, 2, 1, 0, 4};
    int r5_lap [6] = '{1, 1, 1, 1, 1, 0};
    int r5_uf  [6] = '{1, 0, 0, 0, 0, 1};
    int r5_zero[6] = '{0, 0, 0, 0, 1, 0};
    int r4_cnt [7] = '{1, 0, 3, 2, 1, 0, 3};
    int r4_lap [7] = '{0, 0, 1, 1, 1, 1, 0};
    int r4_uf  [7] = '{0, 0, 1, 0, 0, 0, 1};
    int r2_cnt [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    int r2_lap [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    int r2_uf  [8] = '{1, 0, 1, 0, 1, 0, 1, 0};

    // ---------------- main sequence ----------------
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        resetn     = 1'b0;
        decrement  = 1'b0;
        load       = 1'b0;
        load_value = 3'd0;

        // Reset state
        #12;
        check_eq("rst_r5_count", int'(count_r5), 0);
        check_eq("rst_r5_lap", int'(lap_r5), 0);
        check_eq("rst_r5_uf", int'(uf_r5), 0);
        check_eq("rst_r5_zero", int'(zero_r5), 1);
        check_eq("rst_r6_count", int'(count_r6), 3);
        check_eq("rst_r6_zero", int'(zero_r6), 0);
        @(negedge clock);
        resetn = 1'b1;

        // RANGE=6, RESET_VALUE=3: idle holds
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("idle_r6_count", int'(count_r6), 3);
            check_eq("idle_r6_uf", int'(uf_r6), 0);
        end

        // RANGE=5: six decrements from 0
        decrement = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("r5_dec_count", int'(count_r5), r5_cnt[i]);
            check_eq("r5_dec_lap", int'(lap_r5), r5_lap[i]);
            check_eq("r5_dec_uf", int'(uf_r5), r5_uf[i]);
            check_eq("r5_dec_zero", int'(zero_r5), r5_zero[i]);
        end

        // RANGE=4: load 2 then seven decrements
        decrement  = 1'b0;
        load       = 1'b1;
        load_value = 3'd2;
        step();
        check_eq("r4_load_count", int'(count_r4), 2);
        check_eq("r4_load_lap", int'(lap_r4), 0);
        load      = 1'b0;
        decrement = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq("r4_dec_count", int'(count_r4), r4_cnt[i]);
            check_eq("r4_dec_lap", int'(lap_r4), r4_lap[i]);
            check_eq("r4_dec_uf", int'(uf_r4), r4_uf[i]);
        end

        // RANGE=5: clamped load, then load beating a concurrent decrement at 0
        decrement  = 1'b0;
        load       = 1'b1;
        load_value = 3'd7;
        step();
        check_eq("r5_clamp_count", int'(count_r5), 4);
        check_eq("r5_clamp_lap", int'(lap_r5), 0);
        check_eq("r5_clamp_uf", int'(uf_r5), 0);
        load_value = 3'd0;
        step();
        check_eq("r5_load0_count", int'(count_r5), 0);
        decrement  = 1'b1;
        load_value = 3'd2;
        step();
        check_eq("r5_ld_dec_count", int'(count_r5), 2);
        check_eq("r5_ld_dec_uf", int'(uf_r5), 0);
        check_eq("r5_ld_dec_lap", int'(lap_r5), 0);

        // RANGE=2: eight decrements from 0
        decrement  = 1'b0;
        load_value = 3'd0;
        step();
        check_eq("r2_load_count", int'(count_r2), 0);
        load      = 1'b0;
        decrement = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("r2_dec_count", int'(count_r2), r2_cnt[i]);
            check_eq("r2_dec_lap", int'(lap_r2), r2_lap[i]);
            check_eq("r2_dec_uf", int'(uf_r2), r2_uf[i]);
        end

        // Random section: synchronise models with a load of 0
        decrement  = 1'b0;
        load       = 1'b1;
        load_value = 3'd0;
        model_edge(load, decrement, load_value);
        step();
        for (int c = 0; c < 300; c++) begin
            decrement  = 1'($urandom_range(0, 1));
            load       = ($urandom_range(0, 7) == 0);
            load_value = 3'($urandom_range(0, 7));
            model_edge(load, decrement, load_value);
            step();
            for (int i = 0; i < 5; i++) begin
                check_eq($sformatf("rnd_r%0d_count", m_range[i]), int'(rnd_cnt[i]), m_cnt[i]);
                check_eq($sformatf("rnd_r%0d_lap", m_range[i]), int'(rnd_lap[i]), m_lap[i]);
                check_eq($sformatf("rnd_r%0d_uf", m_range[i]), int'(rnd_uf[i]), m_uf[i]);
                check_eq($sformatf("rnd_r%0d_zero", m_range[i]), int'(rnd_zero[i]), (m_cnt[i] == 0) ? 1 : 0);
                check_eq($sformatf("rnd_r%0d_inrange", m_range[i]), (int'(rnd_cnt[i]) < m_range[i]) ? 1 : 0, 1);
            end
        end

        // RANGE=6: reach 0 with lap set, then asynchronous reset mid-cycle
        decrement  = 1'b0;
        load       = 1'b1;
        load_value = 3'd0;
        step();
        check_eq("r6_load_count", int'(count_r6), 0);
        load      = 1'b0;
        decrement = 1'b1;
        step();
        check_eq("r6_wrap_count", int'(count_r6), 5);
        check_eq("r6_wrap_lap", int'(lap_r6), 1);
        check_eq("r6_wrap_uf", int'(uf_r6), 1);
        repeat (5) step();
        check_eq("r6_pre_rst_count", int'(count_r6), 0);
        check_eq("r6_pre_rst_lap", int'(lap_r6), 1);
        #3;
        resetn = 1'b0;
        #1;
        check_eq("r6_async_rst_count", int'(count_r6), 3);
        check_eq("r6_async_rst_lap", int'(lap_r6), 0);
        check_eq("r6_async_rst_uf", int'(uf_r6), 0);
        check_eq("r5_async_rst_count", int'(count_r5), 0);
        step();
        check_eq("r6_held_rst_count", int'(count_r6), 3);
        @(negedge clock);
        resetn = 1'b1;
        step();
        check_eq("r6_post_rst_count", int'(count_r6), 2);
        check_eq("r6_post_rst_uf", int'(uf_r6), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
